// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//
// Memory-access pipeline stage. Takes the EX/MEM register outputs, runs
// loads and stores over a req/ack data bus, and registers the write-back
// result into the MEM/WB boundary. Non-memory instructions pass through with
// one cycle of latency. While a bus transaction is outstanding, stallreq
// holds the upstream stages.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   mem_wd/mem_wreg/mem_wdata destination, write-enable and ALU result
//   mem_op                    000 NONE, 001 LB, 010 LBU, 011 LW, 100 SB,
//                             101 SW, 110/111 NONE
//   mem_addr/mem_sdata        byte address and store data
//   bus_req/we/addr/sel/wdata registered bus request (sel[3] = bits 31:24)
//   bus_ack/bus_rdata         one-cycle completion and read data
//   stallreq                  combinational upstream hold
//   wb_wd/wb_wreg/wb_wdata    registered write-back result
//   align_err                 one-cycle misaligned LW/SW flag
//
// Build option
//   MEM_ALIGN_CHECK_EN : when defined, LW/SW with addr[1:0] != 0 issue no
//   bus transaction, complete in one cycle with wb_wreg = 0 and pulse
//   align_err. When undefined, the access is issued as-is and align_err is
//   tied to 0.
// -----------------------------------------------------------------------------
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stallreq,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        align_err
);

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_SB  = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      state_r;
  logic        bus_req_r;
  logic        bus_we_r;
  logic [31:0] bus_addr_r;
  logic [3:0]  bus_sel_r;
  logic [31:0] bus_wdata_r;
  logic [4:0]  wb_wd_r;
  logic        wb_wreg_r;
  logic [31:0] wb_wdata_r;

  logic        is_load_s;
  logic        is_store_s;
  logic        is_mem_s;
  logic        issue_s;
  logic        stallreq_s;
  logic [3:0]  sel_s;
  logic [31:0] st_data_s;
  logic [31:0] ld_data_s;
  logic [7:0]  ld_byte_s;
  logic [4:0]  res_wd_s;
  logic        res_wreg_s;
  logic [31:0] res_wdata_s;

  // Big-endian lane map: byte address 0 lives in bits 31:24.
  function automatic logic [3:0] lane_sel(input logic [1:0] lane);
    case (lane)
      2'd0:    lane_sel = 4'b1000;
      2'd1:    lane_sel = 4'b0100;
      2'd2:    lane_sel = 4'b0010;
      2'd3:    lane_sel = 4'b0001;
      default: lane_sel = 4'b0000;
    endcase
  endfunction

  // Extract the byte addressed by lane from a big-endian word.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    lane_byte = word[31:24];
      2'd1:    lane_byte = word[23:16];
      2'd2:    lane_byte = word[15:8];
      2'd3:    lane_byte = word[7:0];
      default: lane_byte = 8'h00;
    endcase
  endfunction

  // Decode the operation into bus attributes for the request phase.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    sel_s      = 4'b0000;
    st_data_s  = 32'h0000_0000;
    case (mem_op)
      OP_LB, OP_LBU: begin
        is_load_s = 1'b1;
        sel_s     = lane_sel(mem_addr[1:0]);
      end
      OP_LW: begin
        is_load_s = 1'b1;
        sel_s     = 4'b1111;
      end
      OP_SB: begin
        is_store_s = 1'b1;
        sel_s      = lane_sel(mem_addr[1:0]);
        st_data_s  = {4{mem_sdata[7:0]}};
      end
      OP_SW: begin
        is_store_s = 1'b1;
        sel_s      = 4'b1111;
        st_data_s  = mem_sdata;
      end
      default: begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
      end
    endcase
  end

  assign is_mem_s = is_load_s | is_store_s;

`ifdef MEM_ALIGN_CHECK_EN
  logic is_word_s;
  logic misalign_s;
  logic align_err_r;

  // Only word accesses can be misaligned; byte accesses hit any lane.
  assign is_word_s  = (mem_op == OP_LW) || (mem_op == OP_SW);
  assign misalign_s = is_word_s && (mem_addr[1:0] != 2'b00);
  assign issue_s    = is_mem_s && !misalign_s;
  assign align_err  = align_err_r;
`else
  assign issue_s    = is_mem_s;
  assign align_err  = 1'b0;
`endif

  // Shape the load data; upstream holds mem_* stable during BUSY, so the
  // live op and address still describe the outstanding access.
  always_comb begin
    ld_byte_s = lane_byte(bus_rdata, mem_addr[1:0]);
    case (mem_op)
      OP_LB:   ld_data_s = {{24{ld_byte_s[7]}}, ld_byte_s};
      OP_LBU:  ld_data_s = {24'h00_0000, ld_byte_s};
      OP_LW:   ld_data_s = bus_rdata;
      default: ld_data_s = 32'h0000_0000;
    endcase
  end

  // Write-back result at completion: loads write, stores retire as bubbles.
  always_comb begin
    if (is_load_s) begin
      res_wd_s    = mem_wd;
      res_wreg_s  = mem_wreg;
      res_wdata_s = ld_data_s;
    end else begin
      res_wd_s    = 5'd0;
      res_wreg_s  = 1'b0;
      res_wdata_s = 32'h0000_0000;
    end
  end

  // Stall while a request is being launched or awaiting its ack.
  always_comb begin
    if (state_r == ST_BUSY) begin
      stallreq_s = ~bus_ack;
    end else begin
      stallreq_s = issue_s;
    end
  end

  // Stage FSM with all bus and write-back outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'h0000_0000;
      bus_sel_r   <= 4'b0000;
      bus_wdata_r <= 32'h0000_0000;
      wb_wd_r     <= 5'd0;
      wb_wreg_r   <= 1'b0;
      wb_wdata_r  <= 32'h0000_0000;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_r <= 1'b0;
`endif
    end else begin
`ifdef MEM_ALIGN_CHECK_EN
      align_err_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            state_r     <= ST_BUSY;
            bus_req_r   <= 1'b1;
            bus_we_r    <= is_store_s;
            bus_addr_r  <= mem_addr;
            bus_sel_r   <= sel_s;
            bus_wdata_r <= st_data_s;
            wb_wd_r     <= 5'd0;
            wb_wreg_r   <= 1'b0;
            wb_wdata_r  <= 32'h0000_0000;
`ifdef MEM_ALIGN_CHECK_EN
          end else if (misalign_s) begin
            // Rejected word access retires like a NONE op without a write.
            wb_wd_r     <= mem_wd;
            wb_wreg_r   <= 1'b0;
            wb_wdata_r  <= mem_wdata;
            align_err_r <= 1'b1;
`endif
          end else begin
            wb_wd_r     <= mem_wd;
            wb_wreg_r   <= mem_wreg;
            wb_wdata_r  <= mem_wdata;
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            state_r    <= ST_IDLE;
            bus_req_r  <= 1'b0;
            bus_we_r   <= 1'b0;
            bus_sel_r  <= 4'b0000;
            wb_wd_r    <= res_wd_s;
            wb_wreg_r  <= res_wreg_s;
            wb_wdata_r <= res_wdata_s;
          end else begin
            wb_wd_r    <= 5'd0;
            wb_wreg_r  <= 1'b0;
            wb_wdata_r <= 32'h0000_0000;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          bus_req_r  <= 1'b0;
          bus_we_r   <= 1'b0;
          bus_sel_r  <= 4'b0000;
          wb_wd_r    <= 5'd0;
          wb_wreg_r  <= 1'b0;
          wb_wdata_r <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_sel   = bus_sel_r;
  assign bus_wdata = bus_wdata_r;
  assign stallreq  = stallreq_s;
  assign wb_wd     = wb_wd_r;
  assign wb_wreg   = wb_wreg_r;
  assign wb_wdata  = wb_wdata_r;

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
//
// Self-checking bench for mem_access. Each instruction pushes its expected
// write-back word {wd, wreg, wdata} into a queue when driven; the entry is
// popped and compared when the stage retires the instruction. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_access;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_LB   = 3'b001;
  localparam logic [2:0] OP_LBU  = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_SB   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;

  logic        clk;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stallreq;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        align_err;

  int          n_chk;
  int          n_fail;
  int          txn_cnt;
  logic [37:0] exp_q[$];

  mem_access dut (
    .clk       (clk),
    .rst       (rst),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_sdata (mem_sdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_sel   (bus_sel),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .stallreq  (stallreq),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .align_err (align_err)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count completed bus transactions (request seen together with ack).
  always @(posedge clk) begin
    if (rst && bus_req && bus_ack) txn_cnt++;
  end

  // Single comparison point: counts and reports mismatches.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference load shaping, written as a shift rather than a lane table.
  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    logic [7:0]  b;
    sh = rdata >> (24 - 8 * int'(addr[1:0]));
    b  = sh[7:0];
    if (op == OP_LW)      return rdata;
    else if (op == OP_LB) return {{24{b[7]}}, b};
    else                  return {24'h0, b};
  endfunction

  task automatic pop_wb(input string tag);
    logic [37:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, ":queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ":wb"}, {26'd0, wb_wd, wb_wreg, wb_wdata}, {26'd0, e});
    end
  endtask

  // Drive one instruction at a falling edge, act as bus slave acking on the
  // n_ack-th BUSY cycle, and check the retired write-back. Ends on a falling
  // edge so the next call issues back-to-back.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [4:0] wd,
                        input logic wreg, input logic [31:0] wdata, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata, input int n_ack,
                        input logic exp_mem, input logic exp_we, input logic [3:0] exp_sel,
                        input logic [31:0] exp_bwd, input logic [37:0] exp_wb);
    int stall_cnt;
    int txn0;
    mem_op    = op;
    mem_wd    = wd;
    mem_wreg  = wreg;
    mem_wdata = wdata;
    mem_addr  = addr;
    mem_sdata = sdata;
    exp_q.push_back(exp_wb);
    #1;
    stall_cnt = stallreq ? 1 : 0;
    chk({tag, ":stall_issue"}, {63'd0, stallreq}, {63'd0, exp_mem});
    txn0 = txn_cnt;
    @(posedge clk);
    @(negedge clk);
    if (exp_mem) begin
      chk({tag, ":req"}, {63'd0, bus_req}, 64'd1);
      chk({tag, ":we"}, {63'd0, bus_we}, {63'd0, exp_we});
      chk({tag, ":addr"}, {32'd0, bus_addr}, {32'd0, addr});
      chk({tag, ":sel"}, {60'd0, bus_sel}, {60'd0, exp_sel});
      if (exp_we) chk({tag, ":bwdata"}, {32'd0, bus_wdata}, {32'd0, exp_bwd});
      chk({tag, ":bubble"}, {26'd0, wb_wd, wb_wreg, wb_wdata}, 64'd0);
      for (int i = 1; i <= n_ack; i++) begin
        if (i == n_ack) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata;
        end
        #1;
        if (stallreq) stall_cnt++;
        @(posedge clk);
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        if (i < n_ack) begin
          chk({tag, ":req_hold"}, {31'd0, bus_req, bus_addr}, {31'd0, 1'b1, addr});
          chk({tag, ":busy_bubble"}, {26'd0, wb_wd, wb_wreg, wb_wdata}, 64'd0);
        end
      end
      chk({tag, ":stall_cycles"}, 64'(stall_cnt), 64'(n_ack));
      chk({tag, ":one_txn"}, 64'(txn_cnt - txn0), 64'd1);
    end
    chk({tag, ":req_low"}, {63'd0, bus_req}, 64'd0);
    pop_wb(tag);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] rd;
    logic [4:0]  wd;
    n_chk     = 0;
    n_fail    = 0;
    txn_cnt   = 0;
    rst       = 1'b0;
    mem_op    = OP_NONE;
    mem_wd    = 5'd0;
    mem_wreg  = 1'b0;
    mem_wdata = 32'h0;
    mem_addr  = 32'h0;
    mem_sdata = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus_req, bus_we, bus_sel, wb_wd, wb_wreg, align_err, stallreq},
        14'd0);
    chk("reset_data", {bus_addr, bus_wdata}, 64'd0);
    chk("reset_wbdata", {32'd0, wb_wdata}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op("pass", OP_NONE, 5'd3, 1'b1, 32'h1234, 32'h0, 32'h0, 32'h0, 0,
           1'b0, 1'b0, 4'b0, 32'h0, {5'd3, 1'b1, 32'h0000_1234});
    run_op("op110", 3'b110, 5'd6, 1'b1, 32'h6666, 32'h8, 32'h0, 32'h0, 0,
           1'b0, 1'b0, 4'b0, 32'h0, {5'd6, 1'b1, 32'h0000_6666});
    run_op("lb", OP_LB, 5'd7, 1'b1, 32'h0, 32'h101, 32'h0, 32'h00F0_0000, 3,
           1'b1, 1'b0, 4'b0100, 32'h0, {5'd7, 1'b1, 32'hFFFF_FFF0});
    run_op("lbu", OP_LBU, 5'd7, 1'b1, 32'h0, 32'h101, 32'h0, 32'h00F0_0000, 3,
           1'b1, 1'b0, 4'b0100, 32'h0, {5'd7, 1'b1, 32'h0000_00F0});
    run_op("sb", OP_SB, 5'd9, 1'b1, 32'h0, 32'h203, 32'h1234_56AB, 32'h0, 1,
           1'b1, 1'b1, 4'b0001, 32'hABAB_ABAB, {5'd0, 1'b0, 32'h0});
    run_op("lw", OP_LW, 5'd4, 1'b1, 32'h0, 32'h400, 32'h0, 32'hDEAD_BEEF, 2,
           1'b1, 1'b0, 4'b1111, 32'h0, {5'd4, 1'b1, 32'hDEAD_BEEF});
    run_op("after_lw", OP_NONE, 5'd5, 1'b1, 32'h55, 32'h0, 32'h0, 32'h0, 0,
           1'b0, 1'b0, 4'b0, 32'h0, {5'd5, 1'b1, 32'h0000_0055});

`ifdef MEM_ALIGN_CHECK_EN
    run_op("sw_mis", OP_SW, 5'd2, 1'b1, 32'h77, 32'h402, 32'hCAFE_F00D, 32'h0, 0,
           1'b0, 1'b0, 4'b0, 32'h0, {5'd2, 1'b0, 32'h0000_0077});
    chk("align_err_pulse", {63'd0, align_err}, 64'd1);
    run_op("after_mis", OP_NONE, 5'd1, 1'b1, 32'h11, 32'h0, 32'h0, 32'h0, 0,
           1'b0, 1'b0, 4'b0, 32'h0, {5'd1, 1'b1, 32'h0000_0011});
    chk("align_err_clear", {63'd0, align_err}, 64'd0);
`else
    run_op("sw_mis", OP_SW, 5'd2, 1'b1, 32'h77, 32'h402, 32'hCAFE_F00D, 32'h0, 1,
           1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D, {5'd0, 1'b0, 32'h0});
    chk("align_err_tied", {63'd0, align_err}, 64'd0);
`endif

    // Randomised loads against the reference model.
    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(1, 3));
      a  = $urandom;
      if (op == OP_LW) a = a & 32'hFFFF_FFFC;
      rd = $urandom;
      wd = 5'($urandom);
      run_op("rand_ld", op, wd, 1'b1, 32'h0, a, 32'h0, rd, int'($urandom_range(1, 3)),
             1'b1, 1'b0, (op == OP_LW) ? 4'b1111 : (4'b1000 >> a[1:0]), 32'h0,
             {wd, 1'b1, model_load(op, a, rd)});
    end

    // Reset during BUSY drops the request at once; a pending ack is ignored.
    mem_op   = OP_LW;
    mem_addr = 32'h800;
    mem_wd   = 5'd8;
    mem_wreg = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pre_req", {63'd0, bus_req}, 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_async_outs", {bus_req, bus_we, bus_sel, wb_wd, wb_wreg, align_err}, 13'd0);
    chk("rst_async_data", {bus_addr, wb_wdata}, 64'd0);
    mem_op  = OP_NONE;
    bus_ack = 1'b1;
    #1;
    chk("rst_stall", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ack_ignored", {63'd0, bus_req, stallreq}, 64'd0);
    bus_ack = 1'b0;
    exp_q.delete();
    run_op("post_rst", OP_NONE, 5'd12, 1'b1, 32'hA5A5_0001, 32'h0, 32'h0, 32'h0, 0,
           1'b0, 1'b0, 4'b0, 32'h0, {5'd12, 1'b1, 32'hA5A5_0001});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
